// File: rtl/dma_multichannel.sv
// Multi-channel memory-to-memory DMA: per-channel src/dst/len registers sharing one
// memory port, moving one byte per READ/WRITE pair under round-robin arbitration.
module dma_multichannel #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 5,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_load,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ADDR_W-1:0] cfg_src,
    input  logic [ADDR_W-1:0] cfg_dst,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_src_inc,
    input  logic              cfg_dst_inc,
    output logic              cfg_ack,
    output logic              cfg_err,
    input  logic [NUM_CH-1:0] start,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] irq,
    input  logic [NUM_CH-1:0] irq_clr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              nW_R,
    output logic              CE,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     grant_q, grant_d;
    logic [CH_W-1:0]     rr_q, rr_d;
    logic [NUM_CH-1:0]   busy_q, busy_d;
    logic [NUM_CH-1:0]   irq_q, irq_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   src_q [NUM_CH];
    logic [ADDR_W-1:0]   src_d [NUM_CH];
    logic [ADDR_W-1:0]   dst_q [NUM_CH];
    logic [ADDR_W-1:0]   dst_d [NUM_CH];
    logic [LEN_W-1:0]    len_q [NUM_CH];
    logic [LEN_W-1:0]    len_d [NUM_CH];
    logic [NUM_CH-1:0]   src_inc_q, src_inc_d;
    logic [NUM_CH-1:0]   dst_inc_q, dst_inc_d;

    // rr pointer holds the highest-priority channel for the next grant
    function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                input logic [CH_W-1:0]   ptr);
        logic [CH_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(ptr) + k) % NUM_CH;
            if (!found && req[idx]) begin
                pick  = CH_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [CH_W-1:0] rr_next(input logic [CH_W-1:0] g);
        return CH_W'((int'(g) + 1) % NUM_CH);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            rr_q      <= '0;
            busy_q    <= '0;
            irq_q     <= '0;
            wdata_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            src_inc_q <= '0;
            dst_inc_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                src_q[i] <= '0;
                dst_q[i] <= '0;
                len_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            busy_q    <= busy_d;
            irq_q     <= irq_d;
            wdata_q   <= wdata_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            src_inc_q <= src_inc_d;
            dst_inc_q <= dst_inc_d;
            for (int i = 0; i < NUM_CH; i++) begin
                src_q[i] <= src_d[i];
                dst_q[i] <= dst_d[i];
                len_q[i] <= len_d[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        busy_d    = busy_q;
        irq_d     = irq_q & ~irq_clr;
        wdata_d   = wdata_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        src_inc_d = src_inc_q;
        dst_inc_d = dst_inc_q;
        CE        = 1'b0;
        nW_R      = 1'b1;
        mem_addr  = '0;

        // Start reads the pre-edge length, so a same-edge config only affects later starts.
        for (int i = 0; i < NUM_CH; i++) begin
            if (start[i] && !busy_q[i]) begin
                if (len_q[i] != '0) busy_d[i] = 1'b1;
                else                irq_d[i]  = 1'b1;
            end
        end

        // Config handshake: cfg_load is a one-cycle request; exactly one of cfg_ack/cfg_err answers it next cycle.
        if (cfg_load) begin
            if ((int'(cfg_ch) < NUM_CH) && !busy_q[cfg_ch]) begin
                src_d[cfg_ch]     = cfg_src;
                dst_d[cfg_ch]     = cfg_dst;
                len_d[cfg_ch]     = cfg_len;
                src_inc_d[cfg_ch] = cfg_src_inc;
                dst_inc_d[cfg_ch] = cfg_dst_inc;
                ack_d             = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (|busy_q) begin
                    state_d = S_READ;
                    grant_d = rr_pick(busy_q, rr_q);
                    rr_d    = rr_next(grant_d);
                end
            end
            S_READ: begin
                CE       = 1'b1;
                mem_addr = src_q[grant_q];
                wdata_d  = mem_rdata;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                CE       = 1'b1;
                nW_R     = 1'b0;
                mem_addr = dst_q[grant_q];
                len_d[grant_q] = len_q[grant_q] - LEN_W'(1);
                src_d[grant_q] = src_q[grant_q] + ADDR_W'(src_inc_q[grant_q]);
                dst_d[grant_q] = dst_q[grant_q] + ADDR_W'(dst_inc_q[grant_q]);
                if (len_q[grant_q] == LEN_W'(1)) begin
                    busy_d[grant_q] = 1'b0;
                    irq_d[grant_q]  = 1'b1;
                end
                if (|busy_d) begin
                    state_d = S_READ;
                    grant_d = rr_pick(busy_d, rr_q);
                    rr_d    = rr_next(grant_d);
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cfg_ack   = ack_q;
    assign cfg_err   = err_q;
    assign busy      = busy_q;
    assign irq       = irq_q;
    assign mem_wdata = wdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dma_multichannel.sv
// Directed bench for dma_multichannel: a behavioural memory plus a linear sequence of
// hand-computed steps covering transfers, arbitration, wrap, config errors and reset.
module tb_dma_multichannel;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_load;
    logic [0:0] cfg_ch;
    logic [9:0] cfg_src, cfg_dst;
    logic [4:0] cfg_len;
    logic       cfg_src_inc, cfg_dst_inc;
    logic       cfg_ack, cfg_err;
    logic [1:0] start, busy, irq, irq_clr;
    logic [9:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic       nW_R, CE;
    logic [1:0] dbg_state;

    logic [7:0] mem [1024];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dma_multichannel #(.NUM_CH(2), .ADDR_W(10), .DATA_W(8), .LEN_W(5)) dut (
        .clk(clk), .rst(rst),
        .cfg_load(cfg_load), .cfg_ch(cfg_ch), .cfg_src(cfg_src), .cfg_dst(cfg_dst),
        .cfg_len(cfg_len), .cfg_src_inc(cfg_src_inc), .cfg_dst_inc(cfg_dst_inc),
        .cfg_ack(cfg_ack), .cfg_err(cfg_err),
        .start(start), .busy(busy), .irq(irq), .irq_clr(irq_clr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .nW_R(nW_R), .CE(CE), .dbg_state(dbg_state)
    );

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (CE && !nW_R) mem[mem_addr] <= mem_wdata;

    function automatic logic [7:0] pat(input int a);
        return 8'((a * 7 + 3) & 255);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int ch, input int src, input int dst, input int len,
                       input logic si, input logic di);
        cfg_ch = 1'(ch); cfg_src = 10'(src); cfg_dst = 10'(dst); cfg_len = 5'(len);
        cfg_src_inc = si; cfg_dst_inc = di; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic start_ch(input logic [1:0] m);
        start = m;
        tick();
        start = 2'b00;
    endtask

    task automatic rw(input string tag, input int rd, input int wr, input logic [7:0] d);
        chk({tag, "_rd_ce"}, CE, 1);
        chk({tag, "_rd_dir"}, nW_R, 1);
        chk({tag, "_rd_addr"}, mem_addr, rd);
        tick();
        chk({tag, "_wr_ce"}, CE, 1);
        chk({tag, "_wr_dir"}, nW_R, 0);
        chk({tag, "_wr_addr"}, mem_addr, wr);
        chk({tag, "_wr_data"}, mem_wdata, d);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = pat(i);
        rst = 1'b0; cfg_load = 1'b0; cfg_ch = '0; cfg_src = '0; cfg_dst = '0; cfg_len = '0;
        cfg_src_inc = 1'b0; cfg_dst_inc = 1'b0; start = '0; irq_clr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_irq", irq, 0);
        chk("rst_ce", CE, 0);
        chk("rst_dir", nW_R, 1);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_ack", cfg_ack, 0);
        chk("rst_err", cfg_err, 0);
        rst = 1'b1;
        tick();

        // 1: single channel, three bytes, both addresses incrementing
        cfg(0, 'h010, 'h200, 3, 1, 1);
        chk("t1_ack", cfg_ack, 1);
        chk("t1_err", cfg_err, 0);
        start_ch(2'b01);
        chk("t1_busy_e0", busy, 2'b01);
        chk("t1_idle_ce", CE, 0);
        chk("t1_ack_pulse", cfg_ack, 0);
        tick();
        rw("t1b0", 'h010, 'h200, pat('h010));
        rw("t1b1", 'h011, 'h201, pat('h011));
        rw("t1b2", 'h012, 'h202, pat('h012));
        chk("t1_busy_done", busy, 0);
        chk("t1_irq", irq, 2'b01);
        chk("t1_ce_idle", CE, 0);
        chk("t1_mem0", mem['h200], pat('h010));
        chk("t1_mem2", mem['h202], pat('h012));
        irq_clr = 2'b01;
        tick();
        irq_clr = 2'b00;
        chk("t1_irq_clr", irq, 0);

        // 2: two channels started together interleave 0,1,0,1 from a fresh pointer
        rst = 1'b0;
        #2;
        rst = 1'b1;
        tick();
        cfg(0, 'h020, 'h240, 2, 1, 1);
        cfg(1, 'h030, 'h250, 2, 1, 1);
        chk("t2_ack1", cfg_ack, 1);
        start_ch(2'b11);
        chk("t2_busy", busy, 2'b11);
        tick();
        rw("t2g0a", 'h020, 'h240, pat('h020));
        rw("t2g1a", 'h030, 'h250, pat('h030));
        rw("t2g0b", 'h021, 'h241, pat('h021));
        chk("t2_busy_mid", busy, 2'b10);
        chk("t2_irq_mid", irq, 2'b01);
        rw("t2g1b", 'h031, 'h251, pat('h031));
        chk("t2_busy_end", busy, 2'b00);
        chk("t2_irq_end", irq, 2'b11);
        chk("t2_ce_end", CE, 0);

        // 3: source wraps past the top of memory, destination fixed
        irq_clr = 2'b11;
        tick();
        irq_clr = 2'b00;
        cfg(0, 'h3FE, 'h3FF, 3, 1, 0);
        start_ch(2'b01);
        tick();
        rw("t3b0", 'h3FE, 'h3FF, pat('h3FE));
        rw("t3b1", 'h3FF, 'h3FF, pat('h3FE));
        rw("t3b2", 'h000, 'h3FF, pat('h000));
        chk("t3_irq", irq, 2'b01);
        chk("t3_mem", mem['h3FF], pat('h000));

        // 4: config rejected while busy; zero-length start; config and start on the same edge
        irq_clr = 2'b11;
        tick();
        irq_clr = 2'b00;
        cfg(1, 'h040, 'h260, 2, 1, 1);
        start_ch(2'b10);
        chk("t4_busy", busy, 2'b10);
        cfg(1, 'h100, 'h300, 5, 1, 1);
        chk("t4_err", cfg_err, 1);
        chk("t4_noack", cfg_ack, 0);
        rw("t4b0", 'h040, 'h260, pat('h040));
        rw("t4b1", 'h041, 'h261, pat('h041));
        chk("t4_err_pulse", cfg_err, 0);
        chk("t4_busy_end", busy, 0);
        chk("t4_irq", irq, 2'b10);
        irq_clr = 2'b10;
        tick();
        irq_clr = 2'b00;
        chk("t4_irq_clr", irq, 0);
        start_ch(2'b10);
        chk("t4_len0_irq", irq, 2'b10);
        chk("t4_len0_busy", busy, 0);
        chk("t4_len0_ce", CE, 0);
        tick();
        chk("t4_len0_ce2", CE, 0);
        cfg_ch = 1'b0; cfg_src = 10'h050; cfg_dst = 10'h270; cfg_len = 5'd1;
        cfg_src_inc = 1'b1; cfg_dst_inc = 1'b1; cfg_load = 1'b1; start = 2'b01;
        tick();
        cfg_load = 1'b0; start = 2'b00;
        chk("t4_same_ack", cfg_ack, 1);
        chk("t4_same_busy", busy, 0);
        chk("t4_same_irq", irq, 2'b11);
        start_ch(2'b01);
        chk("t4_new_busy", busy, 2'b01);
        tick();
        rw("t4new", 'h050, 'h270, pat('h050));
        chk("t4_new_done", busy, 0);

        // 5: reset during a WRITE abandons the byte, then a fresh transfer runs
        cfg(0, 'h060, 'h280, 4, 1, 1);
        start_ch(2'b01);
        tick();
        tick();
        chk("t5_in_write", nW_R, 0);
        #1;
        rst = 1'b0;
        #1;
        chk("t5_rst_ce", CE, 0);
        chk("t5_rst_dir", nW_R, 1);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_irq", irq, 0);
        chk("t5_rst_addr", mem_addr, 0);
        chk("t5_rst_wdata", mem_wdata, 0);
        #2;
        rst = 1'b1;
        tick();
        chk("t5_post_ce", CE, 0);
        chk("t5_no_write", mem['h280], pat('h280));
        cfg(0, 'h060, 'h280, 2, 1, 1);
        start_ch(2'b01);
        tick();
        rw("t5b0", 'h060, 'h280, pat('h060));
        rw("t5b1", 'h061, 'h281, pat('h061));
        chk("t5_irq", irq, 2'b01);
        chk("t5_busy", busy, 0);

        // 6: irq set beats a clear on the same edge
        irq_clr = 2'b01;
        tick();
        irq_clr = 2'b00;
        chk("t6_pre_clr", irq, 0);
        cfg(0, 'h070, 'h290, 1, 1, 1);
        start_ch(2'b01);
        tick();
        chk("t6_rd_addr", mem_addr, 'h070);
        tick();
        chk("t6_wr_dir", nW_R, 0);
        irq_clr = 2'b01;
        tick();
        chk("t6_set_wins", irq, 2'b01);
        chk("t6_busy", busy, 0);
        tick();
        irq_clr = 2'b00;
        chk("t6_cleared", irq, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
